// File: rtl/nec_pkg.sv
// Shared NEC protocol definitions: FSM state encoding, segment lengths in
// units, and the unit-length derivation used by both transmitter and receiver.
package nec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4,
        ST_STOP_MARK  = 3'd5,
        ST_GAP        = 3'd6
    } nec_state_e;

    localparam logic [4:0] LEAD_MARK_U  = 5'd16;
    localparam logic [4:0] LEAD_SPACE_U = 5'd8;
    localparam logic [4:0] REP_SPACE_U  = 5'd4;
    localparam logic [4:0] BIT_MARK_U   = 5'd1;
    localparam logic [4:0] BIT0_SPACE_U = 5'd1;
    localparam logic [4:0] BIT1_SPACE_U = 5'd3;
    localparam logic [4:0] STOP_U       = 5'd1;
    localparam logic [7:0] FRAME_U      = 8'd192;

    // One NEC unit is 562.5 us, i.e. clk_freq * 9 / 16000 cycles (truncated).
    function automatic int unit_cycles(input int clk_freq);
        return int'((longint'(clk_freq) * 64'sd9) / 64'sd16000);
    endfunction

endpackage

// File: rtl/nec_tx_tick.sv
// Cycle-in-unit counter for the NEC transmitter: pulses unit_tick once every
// UNIT cycles while enabled, restarting from zero on clear.
module nec_tx_tick
    import nec_pkg::*;
#(
    parameter int UNIT = 28125
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic unit_tick
);

    localparam int CW = (UNIT > 1) ? $clog2(UNIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(UNIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    logic [CW-1:0] cnt_r;

    // Free-running unit divider, held at zero while the transmitter is idle
    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear) begin
            cnt_r <= CNT_ZERO;
        end else if (!enable) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign unit_tick = enable && (cnt_r == CNT_LAST);

endmodule

// File: rtl/nec_tx.sv
// NEC infrared frame transmitter (data and repeat frames, 108 ms frame period).
// Define NEC_TX_CARRIER_EN to modulate marks with the IR carrier instead of baseband levels.
module nec_tx
    import nec_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int CARRIER_FREQ = 38_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] tx_addr,
    input  logic [7:0] tx_cmd,
    input  logic       tx_repeat,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       remote_out
);

    localparam int UNIT = unit_cycles(CLK_FREQ);

    if (CARRIER_FREQ <= 0 || CARRIER_FREQ > CLK_FREQ) begin : g_bad_carrier
        $error("nec_tx: CARRIER_FREQ must be in 1..CLK_FREQ");
    end

    nec_state_e  state_r;
    nec_state_e  state_s;
    logic [4:0]  unit_cnt_r;
    logic [4:0]  bit_idx_r;
    logic [7:0]  frame_cnt_r;
    logic [31:0] data_r;
    logic        repeat_r;
    logic        tx_ready_r;
    logic        tx_done_r;
    logic        remote_out_r;
    logic        start_s;
    logic        busy_s;
    logic        unit_tick_s;
    logic        seg_end_s;
    logic        is_mark_s;
    logic [4:0]  seg_len_s;

    // tx_ready_r is only ever high in IDLE, so it doubles as the accept qualifier
    assign start_s   = tx_valid && tx_ready_r;
    assign busy_s    = (state_r != ST_IDLE);
    assign is_mark_s = (state_r == ST_LEAD_MARK) || (state_r == ST_BIT_MARK) ||
                       (state_r == ST_STOP_MARK);

    nec_tx_tick #(
        .UNIT (UNIT)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .clear     (start_s),
        .enable    (busy_s),
        .unit_tick (unit_tick_s)
    );

    // Length in units of the segment currently being sent
    always_comb begin
        seg_len_s = 5'd0;
        case (state_r)
            ST_LEAD_MARK:  seg_len_s = LEAD_MARK_U;
            ST_LEAD_SPACE: if (repeat_r) seg_len_s = REP_SPACE_U; else seg_len_s = LEAD_SPACE_U;
            ST_BIT_MARK:   seg_len_s = BIT_MARK_U;
            ST_BIT_SPACE:  if (data_r[0]) seg_len_s = BIT1_SPACE_U; else seg_len_s = BIT0_SPACE_U;
            ST_STOP_MARK:  seg_len_s = STOP_U;
            default:       seg_len_s = 5'd0;
        endcase
    end

    assign seg_end_s = unit_tick_s && (unit_cnt_r == (seg_len_s - 5'd1));

    // Frame sequencing; GAP is timed against the whole frame, not its own length
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:       if (start_s) state_s = ST_LEAD_MARK; else state_s = ST_IDLE;
            ST_LEAD_MARK:  if (seg_end_s) state_s = ST_LEAD_SPACE; else state_s = ST_LEAD_MARK;
            ST_LEAD_SPACE: begin
                if (seg_end_s) begin
                    if (repeat_r) state_s = ST_STOP_MARK; else state_s = ST_BIT_MARK;
                end else begin
                    state_s = ST_LEAD_SPACE;
                end
            end
            ST_BIT_MARK:   if (seg_end_s) state_s = ST_BIT_SPACE; else state_s = ST_BIT_MARK;
            ST_BIT_SPACE: begin
                if (seg_end_s) begin
                    if (bit_idx_r == 5'd31) state_s = ST_STOP_MARK; else state_s = ST_BIT_MARK;
                end else begin
                    state_s = ST_BIT_SPACE;
                end
            end
            ST_STOP_MARK:  if (seg_end_s) state_s = ST_GAP; else state_s = ST_STOP_MARK;
            ST_GAP: begin
                if (unit_tick_s && (frame_cnt_r == (FRAME_U - 8'd1))) state_s = ST_IDLE;
                else state_s = ST_GAP;
            end
            default:       state_s = ST_IDLE;
        endcase
    end

    // State, counters, latched request and handshake/done flags
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r     <= ST_IDLE;
            unit_cnt_r  <= 5'd0;
            bit_idx_r   <= 5'd0;
            frame_cnt_r <= 8'd0;
            data_r      <= 32'd0;
            repeat_r    <= 1'b0;
            tx_ready_r  <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            tx_ready_r <= (state_s == ST_IDLE);
            tx_done_r  <= (state_r == ST_STOP_MARK) && seg_end_s;
            if (start_s) begin
                data_r      <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
                repeat_r    <= tx_repeat;
                unit_cnt_r  <= 5'd0;
                bit_idx_r   <= 5'd0;
                frame_cnt_r <= 8'd0;
            end else begin
                if (state_s != state_r) begin
                    unit_cnt_r <= 5'd0;
                end else if (unit_tick_s && (state_r != ST_GAP)) begin
                    unit_cnt_r <= unit_cnt_r + 5'd1;
                end
                if ((state_r == ST_BIT_SPACE) && seg_end_s) begin
                    bit_idx_r <= bit_idx_r + 5'd1;
                    data_r    <= {1'b0, data_r[31:1]};
                end
                if (unit_tick_s && (frame_cnt_r != FRAME_U)) begin
                    frame_cnt_r <= frame_cnt_r + 8'd1;
                end
            end
        end
    end

`ifdef NEC_TX_CARRIER_EN
    localparam int DIV = CLK_FREQ / CARRIER_FREQ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(DIV / 3);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [PW-1:0] PHASE_ZERO = PW'(0);

    logic [PW-1:0] phase_r;

    // Carrier output: spaces separate every mark, so the phase restarts per mark
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            phase_r      <= PHASE_ZERO;
            remote_out_r <= 1'b0;
        end else if (is_mark_s) begin
            remote_out_r <= (phase_r < PHASE_HIGH);
            if (phase_r == PHASE_LAST) phase_r <= PHASE_ZERO;
            else phase_r <= phase_r + PHASE_ONE;
        end else begin
            phase_r      <= PHASE_ZERO;
            remote_out_r <= 1'b0;
        end
    end
`else
    // Baseband output: active-low mark, one cycle behind the FSM
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            remote_out_r <= 1'b1;
        end else begin
            remote_out_r <= ~is_mark_s;
        end
    end
`endif

    assign tx_ready   = tx_ready_r;
    assign tx_done    = tx_done_r;
    assign remote_out = remote_out_r;

endmodule

// File: tb/tb_nec_tx.sv
// Directed bench for nec_tx (baseband build) at a reduced clock so that one
// unit is 9 cycles and a full 192-unit frame is 1728 cycles.
`timescale 1ns/1ps
module tb_nec_tx;

    localparam int CLK_FREQ = 16000;
    localparam int U        = 9;
    localparam int FRAME    = 192 * U;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] tx_addr;
    logic [7:0] tx_cmd;
    logic       tx_repeat;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       remote_out;

    int   cyc = 0;
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   edge_q[$];
    int   done_q[$];
    int   exp_q[$];
    logic last_lvl = 1'b1;

    nec_tx #(
        .CLK_FREQ     (CLK_FREQ),
        .CARRIER_FREQ (1000)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .tx_addr    (tx_addr),
        .tx_cmd     (tx_cmd),
        .tx_repeat  (tx_repeat),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .remote_out (remote_out)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record the cycle of every level change on remote_out and every tx_done pulse
    always @(negedge sys_clk) begin
        if (sys_rst === 1'b1) begin
            last_lvl <= 1'b1;
        end else begin
            if (remote_out !== last_lvl) edge_q.push_back(cyc);
            last_lvl <= remote_out;
        end
        if (tx_done === 1'b1) done_q.push_back(cyc);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        edge_q.delete();
        done_q.delete();
        exp_q.delete();
    endtask

    // Expected edge cycles of one frame whose lead mark starts at t0
    task automatic build_exp(input int t0, input bit rep, input logic [7:0] a, input logic [7:0] c);
        int          t;
        logic [31:0] bits;
        bits = {~c, c, ~a, a};
        t = t0;
        exp_q.push_back(t);
        t += 16 * U;
        exp_q.push_back(t);
        if (rep) begin
            t += 4 * U;
        end else begin
            t += 8 * U;
            for (int i = 0; i < 32; i++) begin
                exp_q.push_back(t);
                t += U;
                exp_q.push_back(t);
                t += bits[i] ? 3 * U : U;
            end
        end
        exp_q.push_back(t);
        t += U;
        exp_q.push_back(t);
    endtask

    task automatic compare_edges(input string pfx);
        check_eq({pfx, "_nedges"}, edge_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < edge_q.size(); i++)
            check_eq($sformatf("%s_edge%0d", pfx, i), edge_q[i], exp_q[i]);
    endtask

    // Present a request and return the cycle of the accepting edge
    task automatic send(input bit rep, input logic [7:0] a, input logic [7:0] c,
                        input bit hold, output int xfer);
        bit got;
        got  = 1'b0;
        xfer = 0;
        @(negedge sys_clk);
        tx_repeat = rep;
        tx_addr   = a;
        tx_cmd    = c;
        tx_valid  = 1'b1;
        for (int k = 0; k < 4000 && !got; k++) begin
            if (tx_ready === 1'b1) begin
                got  = 1'b1;
                xfer = cyc + 1;
            end else begin
                @(negedge sys_clk);
            end
        end
        check_eq("send_accept", got, 1);
        @(negedge sys_clk);
        if (!hold) tx_valid = 1'b0;
        tx_addr   = ~a;
        tx_cmd    = ~c;
        tx_repeat = ~rep;
    endtask

    task automatic wait_ready(output int rc);
        bit got;
        got = 1'b0;
        rc  = 0;
        for (int k = 0; k < 4000 && !got; k++) begin
            @(negedge sys_clk);
            if (tx_ready === 1'b1) begin
                got = 1'b1;
                rc  = cyc;
            end
        end
        check_eq("ready_wait", got, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int xfer;
        int x2;
        int rc;
        sys_rst   = 1'b1;
        tx_valid  = 1'b0;
        tx_repeat = 1'b0;
        tx_addr   = 8'h00;
        tx_cmd    = 8'h00;

        // Reset values and quiet idle
        repeat (3) @(negedge sys_clk);
        check_eq("rst_ready", tx_ready, 0);
        check_eq("rst_out", remote_out, 1);
        check_eq("rst_done", tx_done, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_eq("ready_after_release", tx_ready, 1);
        repeat (100) @(negedge sys_clk);
        check_eq("idle_edges", edge_q.size(), 0);
        check_eq("idle_done", done_q.size(), 0);
        check_eq("idle_out", remote_out, 1);

        // Data frame addr=0x00 cmd=0xAA
        clear_q();
        send(1'b0, 8'h00, 8'hAA, 1'b0, xfer);
        wait_ready(rc);
        check_eq("d1_ready_at", rc, xfer + FRAME);
        build_exp(xfer + 1, 1'b0, 8'h00, 8'hAA);
        compare_edges("d1");
        check_eq("d1_ndone", done_q.size(), 1);
        if (done_q.size() > 0) check_eq("d1_done_at", done_q[0], exp_q[exp_q.size() - 1] - 1);

        // Repeat frame; address/command must be ignored
        clear_q();
        send(1'b1, 8'h5A, 8'hC3, 1'b0, xfer);
        wait_ready(rc);
        check_eq("rep_ready_at", rc, xfer + FRAME);
        build_exp(xfer + 1, 1'b1, 8'h5A, 8'hC3);
        compare_edges("rep");
        check_eq("rep_ndone", done_q.size(), 1);
        if (done_q.size() > 0) check_eq("rep_done_at", done_q[0], exp_q[exp_q.size() - 1] - 1);

        // tx_valid held high: back-to-back frames, mid-frame input changes ignored
        clear_q();
        send(1'b0, 8'h5A, 8'h3C, 1'b1, xfer);
        repeat (300) @(negedge sys_clk);
        tx_addr   = 8'hC3;
        tx_cmd    = 8'h81;
        tx_repeat = 1'b0;
        tx_valid  = 1'b0;
        @(negedge sys_clk);
        tx_valid = 1'b1;
        wait_ready(rc);
        x2 = rc + 1;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        check_eq("b2b_period", x2 - xfer, FRAME + 1);
        wait_ready(rc);
        build_exp(xfer + 1, 1'b0, 8'h5A, 8'h3C);
        build_exp(x2 + 1, 1'b0, 8'hC3, 8'h81);
        compare_edges("b2b");
        check_eq("b2b_ndone", done_q.size(), 2);

        // Reset during bit 10 (addr=0xFF: bits 0-7 are '1', bits 8-9 are '0')
        clear_q();
        send(1'b0, 8'hFF, 8'h00, 1'b0, xfer);
        while (cyc < xfer + 1 + 16 * U + 8 * U + 8 * 4 * U + 2 * 2 * U + 4) @(negedge sys_clk);
        check_eq("b10_mark", remote_out, 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check_eq("midrst_out", remote_out, 1);
        check_eq("midrst_ready", tx_ready, 0);
        check_eq("midrst_done", tx_done, 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        check_eq("midrst_ready_rel", tx_ready, 1);

        // Reset and transfer in the same cycle: reset wins
        repeat (5) @(negedge sys_clk);
        clear_q();
        sys_rst  = 1'b1;
        tx_valid = 1'b1;
        @(negedge sys_clk);
        sys_rst  = 1'b0;
        tx_valid = 1'b0;
        repeat (40) @(negedge sys_clk);
        check_eq("rstwin_edges", edge_q.size(), 0);
        check_eq("rstwin_ready", tx_ready, 1);

        // First frame after reset is complete from a full lead mark
        clear_q();
        send(1'b0, 8'h12, 8'h34, 1'b0, xfer);
        wait_ready(rc);
        check_eq("post_ready_at", rc, xfer + FRAME);
        build_exp(xfer + 1, 1'b0, 8'h12, 8'h34);
        compare_edges("post");
        check_eq("post_ndone", done_q.size(), 1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
